// File: rtl/global_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : global_buffer_pkg
// Purpose  : Shared widths, packet/header types and store-DMA state encoding
//            for the GLB tile.
// Revision : 1.0 - initial store-DMA types
// ============================================================================
package global_buffer_pkg;

  localparam int GLB_ADDR_WIDTH       = 21;
  localparam int CGRA_DATA_WIDTH      = 16;
  localparam int BANK_DATA_WIDTH      = 64;
  localparam int BANK_STRB_WIDTH      = BANK_DATA_WIDTH / 8;
  localparam int BANK_BYTE_OFFSET     = 3;
  localparam int QUEUE_DEPTH          = 4;
  localparam int MAX_NUM_WORDS_WIDTH  = 16;
  localparam int ST_DMA_LANES         = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int ST_DMA_LANE_STRB     = BANK_STRB_WIDTH / ST_DMA_LANES;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
  } dma_st_header_t;

  typedef struct packed {
    logic                       wr_en;
    logic [BANK_STRB_WIDTH-1:0] wr_strb;
    logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
    logic [BANK_DATA_WIDTH-1:0] wr_data;
  } wr_packet_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } st_dma_state_e;

endpackage
`default_nettype wire

// File: rtl/glb_st_hdr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : glb_st_hdr_fifo
// Purpose  : DEPTH-entry FIFO of store-DMA headers. Pushes while full are
//            ignored; simultaneous push and pop are both honoured.
// Revision : 1.0 - initial version
// ============================================================================
module glb_st_hdr_fifo
  import global_buffer_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push,
  input  dma_st_header_t push_data,
  input  logic           pop,
  output dma_st_header_t pop_data,
  output logic           full,
  output logic           empty
);

  localparam int c_PTR_W = $clog2(DEPTH);

  dma_st_header_t       r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign full      = (r_count == (c_PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/glb_store_dma.sv
`default_nettype none
// ============================================================================
// Module   : glb_store_dma
// Purpose  : Packs the 16-bit CGRA-to-GLB stream into 64-bit bank writes,
//            one queued header (start_addr, num_words) per transfer.
// Options  : GLB_ST_DMA_DROP_CNT_EN - adds st_dma_drop_cnt, a saturating
//            count of beats that arrived with no active header.
// Revision : 1.0 - initial version
// ============================================================================
module glb_store_dma
  import global_buffer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_st_dma_on,
  input  logic                       st_hdr_push,
  input  dma_st_header_t             st_hdr,
  output logic                       st_hdr_full,
  input  logic [CGRA_DATA_WIDTH-1:0] stream_data_f2g,
  input  logic                       stream_data_valid_f2g,
  output wr_packet_t                 st_dma_wr,
  output logic                       st_dma_done_pulse
`ifdef GLB_ST_DMA_DROP_CNT_EN
  ,
  output logic [15:0]                st_dma_drop_cnt
`endif
);

  dma_st_header_t                 w_hdr;
  logic                           w_empty;
  logic                           w_pop;
  logic [1:0]                     w_lane;
  logic                           w_flush;
  logic [BANK_DATA_WIDTH-1:0]     w_buf_merged;
  logic [BANK_STRB_WIDTH-1:0]     w_strb_merged;
  logic                           w_unused_hdr;

  st_dma_state_e                  r_state;
  logic [GLB_ADDR_WIDTH-1:0]      r_addr;
  logic [MAX_NUM_WORDS_WIDTH-1:0] r_remain;
  logic [BANK_DATA_WIDTH-1:0]     r_buf;
  logic [BANK_STRB_WIDTH-1:0]     r_strb;
  wr_packet_t                     r_wr;
  logic                           r_done;

  glb_st_hdr_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_hdr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (st_hdr_push),
    .push_data (st_hdr),
    .pop       (w_pop),
    .pop_data  (w_hdr),
    .full      (st_hdr_full),
    .empty     (w_empty)
  );

  // The header valid bit and start_addr[0] are not used: addresses are
  // forced to a 16-bit boundary.
  assign w_unused_hdr = ^{w_hdr.valid, w_hdr.start_addr[0]};

  assign w_pop   = (r_state == ST_IDLE) && cfg_st_dma_on && !w_empty;
  assign w_lane  = r_addr[BANK_BYTE_OFFSET-1:1];
  assign w_flush = (w_lane == 2'(ST_DMA_LANES-1)) ||
                   (r_remain == MAX_NUM_WORDS_WIDTH'(1));

  // Lane buffer and strobe with the current beat merged in.
  always_comb begin
    w_buf_merged  = r_buf;
    w_strb_merged = r_strb;
    w_buf_merged[w_lane*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH]    = stream_data_f2g;
    w_strb_merged[w_lane*ST_DMA_LANE_STRB +: ST_DMA_LANE_STRB] = '1;
  end

  // Header pop / beat packing FSM with registered write packet and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_buf    <= '0;
      r_strb   <= '0;
      r_wr     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_wr.wr_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_addr   <= {w_hdr.start_addr[GLB_ADDR_WIDTH-1:1], 1'b0};
            r_remain <= w_hdr.num_words;
            if (w_hdr.num_words == '0) r_done  <= 1'b1;
            else                       r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (stream_data_valid_f2g) begin
            r_addr   <= r_addr + GLB_ADDR_WIDTH'(2);
            r_remain <= r_remain - MAX_NUM_WORDS_WIDTH'(1);
            if (w_flush) begin
              r_wr.wr_en   <= 1'b1;
              r_wr.wr_strb <= w_strb_merged;
              r_wr.wr_addr <= {r_addr[GLB_ADDR_WIDTH-1:BANK_BYTE_OFFSET],
                               {BANK_BYTE_OFFSET{1'b0}}};
              r_wr.wr_data <= w_buf_merged;
              r_buf        <= '0;
              r_strb       <= '0;
            end else begin
              r_buf  <= w_buf_merged;
              r_strb <= w_strb_merged;
            end
            if (r_remain == MAX_NUM_WORDS_WIDTH'(1)) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign st_dma_wr         = r_wr;
  assign st_dma_done_pulse = r_done;

`ifdef GLB_ST_DMA_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = (r_state == ST_IDLE) && stream_data_valid_f2g;

  // Saturating count of beats seen with no active header.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1)    r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign st_dma_drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire
